// File: rtl/extram_bridge_if.sv
// extram_bridge_if: CPU external-RAM port bundle.
// master = CPU side, slave = bridge side.
interface extram_bridge_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   extram_a;
  logic [DATA_W-1:0]   extram_d_out;
  logic                extram_cs;
  logic                extram_oe;
  logic [DATA_W/8-1:0] extram_wstrb;
  logic [DATA_W-1:0]   extram_d_in;
  logic                extram_ready;

  modport master (
    output extram_a, extram_d_out, extram_cs,
    output extram_oe, extram_wstrb,
    input  extram_d_in, extram_ready
  );

  modport slave (
    input  extram_a, extram_d_out, extram_cs,
    input  extram_oe, extram_wstrb,
    output extram_d_in, extram_ready
  );
endinterface

// File: rtl/extram_bridge.sv
// extram_bridge: CPU extram port to NUM_SLAVES mapped peripherals.
// Optional WAIT abort with sticky bus_err: define EXTRAM_BRIDGE_TIMEOUT_EN.
module extram_bridge #(
  parameter int NUM_SLAVES  = 4,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int SEL_LSB     = 11,
  parameter int TIMEOUT     = 255,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset_,
  extram_bridge_if.slave           cpu,
  output logic [NUM_SLAVES-1:0]    slv_cs,
  output logic [ADDR_W-1:0]        slv_a,
  output logic [DATA_W-1:0]        slv_d_out,
  output logic                     slv_oe,
  output logic [DATA_W/8-1:0]      slv_wstrb,
  input  logic [NUM_SLAVES*DATA_W-1:0] slv_d_in,
  input  logic [NUM_SLAVES-1:0]    slv_wait,
  input  logic [NUM_SLAVES-1:0]    slv_irq,
  output logic [NUM_SLAVES-1:0]    irq_out,
  output logic                     bus_err,
  input  logic                     bus_err_clr
);
  localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  state_t            state, state_nx;
  logic [SEL_W-1:0]  idx, idx_q;
  logic              mapped, cap, fin, abort, cnt_hit;
  logic [DATA_W-1:0] rd_data, d_in_q;
  logic              wt, ready_q;

  assign idx    = cpu.extram_a[SEL_LSB +: SEL_W];
  assign mapped = {1'b0, idx} < (SEL_W+1)'(NUM_SLAVES);

  // Only the captured slave's wait and data are visible.
  always_comb begin
    rd_data = '0;
    wt      = 1'b0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (idx_q == SEL_W'(k)) begin
        rd_data = slv_d_in[k*DATA_W +: DATA_W];
        wt      = slv_wait[k];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    cap      = 1'b0;
    fin      = 1'b0;
    abort    = 1'b0;
    unique case (state)
      IDLE: begin
        if (cpu.extram_cs) begin
          cap      = 1'b1;
          state_nx = mapped ? ACCESS : DONE;
        end
      end
      ACCESS: state_nx = WAIT;
      WAIT: begin
        if (!wt) begin
          fin      = 1'b1;
          state_nx = DONE;
        end else if (cnt_hit) begin
          abort    = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: if (!cpu.extram_cs) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      slv_cs    <= '0;
      slv_a     <= '0;
      slv_d_out <= '0;
      slv_oe    <= 1'b0;
      slv_wstrb <= '0;
      idx_q     <= '0;
      d_in_q    <= '0;
      ready_q   <= 1'b0;
    end else begin
      slv_cs  <= '0;
      ready_q <= 1'b0;
      if (cap) begin
        slv_a     <= cpu.extram_a;
        slv_d_out <= cpu.extram_d_out;
        slv_oe    <= cpu.extram_oe;
        slv_wstrb <= cpu.extram_wstrb;
        idx_q     <= idx;
        if (mapped) begin
          slv_cs <= NUM_SLAVES'(1) << idx;
        end else begin
          d_in_q  <= '0;
          ready_q <= 1'b1;
        end
      end
      if (fin) begin
        ready_q <= 1'b1;
        if (slv_oe) d_in_q <= rd_data;
      end
      if (abort) begin
        ready_q <= 1'b1;
        d_in_q  <= '1;
      end
    end
  end

  assign cpu.extram_d_in  = d_in_q;
  assign cpu.extram_ready = ready_q;

  logic [NUM_SLAVES-1:0] sync_q [SYNC_STAGES];

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= slv_irq;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign irq_out = sync_q[SYNC_STAGES-1];

`ifdef EXTRAM_BRIDGE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;
  logic          err_q;

  // Abort fires as the TIMEOUT-th waiting cycle ends.
  assign cnt_hit = (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      if (state == ACCESS)          cnt <= '0;
      else if (state == WAIT && wt) cnt <= cnt + CW'(1);
      if (abort)            err_q <= 1'b1;
      else if (bus_err_clr) err_q <= 1'b0;
    end
  end

  assign bus_err = err_q;
`else
  localparam int unused_tmo = TIMEOUT;
  logic unused_clr;

  assign unused_clr = bus_err_clr;
  assign cnt_hit    = 1'b0;
  assign bus_err    = 1'b0;
`endif
endmodule

// File: tb/tb_extram_bridge.sv
// tb_extram_bridge: scoreboard bench, NUM_SLAVES=3 so idx 3 is unmapped.
// Timeout cases run when EXTRAM_BRIDGE_TIMEOUT_EN is defined.
module tb_extram_bridge;
  localparam int NS = 3;
  localparam int AW = 16;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset_ = 1'b0;
  logic [NS-1:0] slv_cs;
  logic [AW-1:0] slv_a;
  logic [DW-1:0] slv_d_out;
  logic          slv_oe;
  logic [3:0]    slv_wstrb;
  logic [NS*DW-1:0] slv_d_in;
  logic [NS-1:0] slv_wait;
  logic [NS-1:0] slv_irq;
  logic [NS-1:0] irq_out;
  logic          bus_err;
  logic          bus_err_clr;

  extram_bridge_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  extram_bridge #(
    .NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW),
    .SEL_LSB(11), .TIMEOUT(255), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .reset_(reset_), .cpu(bus),
    .slv_cs(slv_cs), .slv_a(slv_a), .slv_d_out(slv_d_out),
    .slv_oe(slv_oe), .slv_wstrb(slv_wstrb), .slv_d_in(slv_d_in),
    .slv_wait(slv_wait), .slv_irq(slv_irq), .irq_out(irq_out),
    .bus_err(bus_err), .bus_err_clr(bus_err_clr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int failures = 0;
  int resp_cnt = 0;
  int want = 0;

  typedef struct {
    logic [31:0] d;
    logic        err;
    int          lat;
    int          t0;
  } rsp_t;

  typedef struct {
    logic [NS-1:0] cs;
    logic [AW-1:0] a;
    logic          oe;
    logic [3:0]    wstrb;
    logic [31:0]   d;
  } cs_t;

  rsp_t rq[$];
  cs_t  cq[$];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Response monitor
  always @(negedge clk) begin
    if (reset_ && bus.extram_ready) begin
      resp_cnt++;
      if (rq.size() == 0) begin
        chk("unexpected_ready", 64'(bus.extram_ready), 64'(0));
      end else begin
        rsp_t e;
        e = rq.pop_front();
        chk("rsp_data", 64'(bus.extram_d_in), 64'(e.d));
        chk("rsp_err", 64'(bus_err), 64'(e.err));
        chk("rsp_latency", 64'(cyc - e.t0), 64'(e.lat));
      end
    end
  end

  // Chip-select monitor
  always @(negedge clk) begin
    if (reset_ && slv_cs != '0) begin
      if (cq.size() == 0) begin
        chk("unexpected_cs", 64'(slv_cs), 64'(0));
      end else begin
        cs_t e;
        e = cq.pop_front();
        chk("cs_onehot", 64'(slv_cs), 64'(e.cs));
        chk("cs_addr", 64'(slv_a), 64'(e.a));
        chk("cs_oe", 64'(slv_oe), 64'(e.oe));
        chk("cs_wstrb", 64'(slv_wstrb), 64'(e.wstrb));
        chk("cs_dout", 64'(slv_d_out), 64'(e.d));
      end
    end
  end

  task automatic issue(input logic [AW-1:0] a, input logic [31:0] d,
                       input logic oe, input logic [3:0] ws,
                       input logic [NS-1:0] cs_exp,
                       input logic [31:0] d_exp, input logic err_exp,
                       input int lat);
    rsp_t r;
    cs_t  c;
    @(negedge clk);
    bus.extram_a     = a;
    bus.extram_d_out = d;
    bus.extram_oe    = oe;
    bus.extram_wstrb = ws;
    bus.extram_cs    = 1'b1;
    r.d = d_exp; r.err = err_exp; r.lat = lat; r.t0 = cyc;
    rq.push_back(r);
    want++;
    if (cs_exp != '0) begin
      c.cs = cs_exp; c.a = a; c.oe = oe; c.wstrb = ws; c.d = d;
      cq.push_back(c);
    end
  endtask

  task automatic wait_resp(input bit drop);
    for (int i = 0; i < 600; i++) begin
      if (resp_cnt >= want) break;
      @(posedge clk);
    end
    if (resp_cnt < want) begin
      chk("resp_timeout", 64'(resp_cnt), 64'(want));
      rq.delete();
      cq.delete();
      want = resp_cnt;
    end
    if (drop) begin
      @(negedge clk);
      bus.extram_cs = 1'b0;
    end
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_d_in"}, 64'(bus.extram_d_in), 64'(0));
    chk({tag, "_ready"}, 64'(bus.extram_ready), 64'(0));
    chk({tag, "_slv_cs"}, 64'(slv_cs), 64'(0));
    chk({tag, "_slv_a"}, 64'(slv_a), 64'(0));
    chk({tag, "_slv_dout"}, 64'(slv_d_out), 64'(0));
    chk({tag, "_slv_oe"}, 64'(slv_oe), 64'(0));
    chk({tag, "_slv_wstrb"}, 64'(slv_wstrb), 64'(0));
    chk({tag, "_irq_out"}, 64'(irq_out), 64'(0));
    chk({tag, "_bus_err"}, 64'(bus_err), 64'(0));
  endtask

  initial begin
    bus.extram_a     = '0;
    bus.extram_d_out = '0;
    bus.extram_cs    = 1'b0;
    bus.extram_oe    = 1'b0;
    bus.extram_wstrb = '0;
    slv_d_in    = {32'hBBBB2222, 32'h12345678, 32'hAAAA0000};
    slv_wait    = '0;
    slv_irq     = '0;
    bus_err_clr = 1'b0;

    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset_ = 1'b1;

    // Read slave 1; slaves 0 and 2 busy but must be ignored
    slv_wait = 3'b101;
    issue(16'h0800, 32'h0, 1'b1, 4'hF, 3'b010,
          32'h12345678, 1'b0, 3);
    wait_resp(1'b1);

    // Write slave 0, wait held 5 cycles from request
    slv_wait = 3'b001;
    issue(16'h0004, 32'hCAFEF00D, 1'b0, 4'b0011, 3'b001,
          32'h12345678, 1'b0, 6);
    repeat (5) @(negedge clk);
    slv_wait = 3'b000;
    wait_resp(1'b1);

    // Unmapped idx 3: no cs, ready next cycle, data 0
    issue(16'h1800, 32'h55, 1'b1, 4'hF, 3'b000,
          32'h0, 1'b0, 1);
    wait_resp(1'b1);

    // Held cs after ready must not retrigger
    issue(16'h1000, 32'h0, 1'b1, 4'hF, 3'b100,
          32'hBBBB2222, 1'b0, 3);
    wait_resp(1'b0);
    repeat (3) @(negedge clk);
    bus.extram_cs = 1'b0;
    issue(16'h0000, 32'h0, 1'b1, 4'hF, 3'b001,
          32'hAAAA0000, 1'b0, 3);
    wait_resp(1'b1);

    // Interrupt synchroniser: two-clock latency, level follows
    @(negedge clk);
    #2 slv_irq = 3'b100;
    @(negedge clk);
    chk("irq_1clk", 64'(irq_out), 64'(3'b000));
    @(negedge clk);
    chk("irq_2clk", 64'(irq_out), 64'(3'b100));
    slv_irq = 3'b000;
    repeat (2) @(negedge clk);
    chk("irq_fall", 64'(irq_out), 64'(3'b000));

`ifdef EXTRAM_BRIDGE_TIMEOUT_EN
    // Stuck slave 2: abort after 255 WAIT cycles
    slv_wait = 3'b100;
    issue(16'h1000, 32'h0, 1'b1, 4'hF, 3'b100,
          32'hFFFFFFFF, 1'b1, 257);
    wait_resp(1'b1);
    chk("err_sticky", 64'(bus_err), 64'(1));
    @(negedge clk);
    bus_err_clr = 1'b1;
    @(negedge clk);
    bus_err_clr = 1'b0;
    chk("err_cleared", 64'(bus_err), 64'(0));
    // Clear coincident with a new abort: set wins
    issue(16'h1000, 32'h00000001, 1'b0, 4'hF, 3'b100,
          32'hFFFFFFFF, 1'b1, 257);
    repeat (256) @(negedge clk);
    bus_err_clr = 1'b1;
    @(negedge clk);
    bus_err_clr = 1'b0;
    wait_resp(1'b1);
    chk("err_set_wins", 64'(bus_err), 64'(1));
    @(negedge clk);
    bus_err_clr = 1'b1;
    @(negedge clk);
    bus_err_clr = 1'b0;
    slv_wait = 3'b000;
`else
    // No timeout: a long wait completes normally, clear ignored
    slv_wait = 3'b100;
    issue(16'h1000, 32'h0, 1'b1, 4'hF, 3'b100,
          32'hBBBB2222, 1'b0, 301);
    repeat (100) @(negedge clk);
    bus_err_clr = 1'b1;
    @(negedge clk);
    bus_err_clr = 1'b0;
    repeat (199) @(negedge clk);
    slv_wait = 3'b000;
    wait_resp(1'b1);
    chk("err_tied_low", 64'(bus_err), 64'(0));
`endif

    // Reset during WAIT: outputs clear, no ready pulse
    slv_wait = 3'b010;
    issue(16'h0800, 32'h0, 1'b1, 4'hF, 3'b010,
          32'h12345678, 1'b0, 3);
    repeat (4) @(negedge clk);
    reset_ = 1'b0;
    bus.extram_cs = 1'b0;
    rq.delete();
    want = resp_cnt;
    #1;
    chk_zero("midreset");
    repeat (2) @(negedge clk);
    reset_ = 1'b1;
    slv_wait = 3'b000;
    repeat (3) @(negedge clk);
    chk("no_ready_after_reset", 64'(resp_cnt), 64'(want));
    issue(16'h0800, 32'h0, 1'b1, 4'hF, 3'b010,
          32'h12345678, 1'b0, 3);
    wait_resp(1'b1);

    repeat (3) @(negedge clk);
    chk("rsp_queue_empty", 64'(rq.size()), 64'(0));
    chk("cs_queue_empty", 64'(cq.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
